logic_bist_checker: RTL and testbench

- Synthesizable self-test engine for the 3-input simple logic unit: drives a/b/c through all 8 input combinations, samples the unit's result, and compares it against a parameterised truth table.
- Replaces the manual stimulus/print flow with an on-chip pass/fail verdict and a per-vector failure bitmap.
- Sits beside the logic unit: it drives the unit's a/b/c inputs, and the unit's result feeds back into result_in.

---
 rtl/logic_bist_checker.sv | 153 +++++++++++++++
 tb/tb_logic_bist_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_bist_checker.sv
// Self-test engine for the 3-input logic unit. It steps a/b/c through all
// eight input combinations, holds each one for SETTLE_CYCLES, samples the
// unit's result and scores it against the EXPECTED truth table
// (bit index = {c,b,a}). The verdict is pass/fail, a mismatch count and a
// per-vector failure bitmap.
//
// state  | meaning
// IDLE   | waiting for start after reset; all results zero
// APPLY  | current vector driven onto a/b/c, settle counter running
// SAMPLE | one cycle: result_in scored against EXPECTED[vec_idx]
// DONE   | verdict held until the next start or reset
module logic_bist_checker #(
  parameter logic [7:0]  EXPECTED      = 8'hF8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       result_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map
);

  // Counter value seen on the last settle cycle of APPLY.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [7:0] fail_q, fail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       mismatch;
  logic [3:0] err_next;
  logic [7:0] fail_next;

  // State and result registers; reset aborts any run and clears every result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fail_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Scoring of the current vector; only committed in SAMPLE. err_count
  // cannot exceed 8 because each of the eight vectors is scored once.
  always_comb begin
    mismatch            = (result_in != EXPECTED[vec_q]);
    err_next            = err_q + {3'd0, mismatch};
    fail_next           = fail_q;
    fail_next[vec_q]    = fail_q[vec_q] | mismatch;
  end

  // Next-state and register updates for the run sequencer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          vec_d   = 3'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          fail_d  = 8'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      S_APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        err_d  = err_next;
        fail_d = fail_next;
        if (vec_q == 3'd7) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == 4'd0);
        end else begin
          state_d = S_APPLY;
          vec_d   = vec_q + 3'd1;
          cnt_d   = 4'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Unit inputs follow the vector only while a run is active, else park at 0.
  always_comb begin
    a_out = busy_q & vec_q[0];
    b_out = busy_q & vec_q[1];
    c_out = busy_q & vec_q[2];
  end

  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_map  = fail_q;

endmodule

// File: tb/tb_logic_bist_checker.sv
// Bench for logic_bist_checker: two instances (settle 2 and settle 1) share
// start/reset and each drives its own model of the logic unit. A time-based
// model predicts every output each cycle from the run's elapsed cycle count.
module tb_logic_bist_checker;

  localparam int SC [2] = '{2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [2:0] mode;
  logic [7:0] rmask;
  logic       glitch [2];
  logic       res    [2];

  logic       a_o [2];
  logic       b_o [2];
  logic       c_o [2];
  logic [2:0] vec_o [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       pass_o [2];
  logic [3:0] err_o [2];
  logic [7:0] fail_o [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference unit: result = (a & b) | c
  function automatic logic golden(int idx);
    return ((idx & 1) != 0 && (idx & 2) != 0) || ((idx & 4) != 0);
  endfunction

  // Unit under test as seen by the checker, with selectable faults.
  function automatic logic unit_res(logic [2:0] m, logic [7:0] rm, int idx);
    case (m)
      3'd1:    return golden(idx) ^ (idx == 3);
      3'd2:    return 1'b0;
      3'd3:    return 1'b1;
      3'd4:    return golden(idx) ^ rm[idx];
      default: return golden(idx);
    endcase
  endfunction

  assign res[0] = unit_res(mode, rmask, int'({c_o[0], b_o[0], a_o[0]})) ^ glitch[0];
  assign res[1] = unit_res(mode, rmask, int'({c_o[1], b_o[1], a_o[1]})) ^ glitch[1];

  logic_bist_checker #(.EXPECTED(8'hF8), .SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .result_in(res[0]),
    .a_out(a_o[0]), .b_out(b_o[0]), .c_out(c_o[0]), .vec_idx(vec_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(err_o[0]), .fail_map(fail_o[0])
  );

  logic_bist_checker #(.EXPECTED(8'hF8), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .result_in(res[1]),
    .a_out(a_o[1]), .b_out(b_o[1]), .c_out(c_o[1]), .vec_idx(vec_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(err_o[1]), .fail_map(fail_o[1])
  );

  // Model: 0 idle, 1 running (m_t edges since start), 2 done.
  int         m_run [2];
  int         m_t   [2];
  logic [7:0] m_bad [2];
  bit         m_valid = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] = 0;
        m_t[i]   = 0;
        m_bad[i] = 8'd0;
        m_valid  = 1;
      end else if (m_run[i] != 1 && start) begin
        m_run[i] = 1;
        m_t[i]   = 0;
        for (int j = 0; j < 8; j++) m_bad[i][j] = (unit_res(mode, rmask, j) != golden(j));
      end else if (m_run[i] == 1) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == 8 * (SC[i] + 1)) m_run[i] = 2;
      end
    end
  end

  function automatic int popc(logic [7:0] v);
    int n = 0;
    for (int j = 0; j < 8; j++) n += int'(v[j]);
    return n;
  endfunction

  // Packed {a,b,c,vec,busy,done,pass,err,fail}
  function automatic logic [20:0] model_out(int i);
    int sp = SC[i] + 1;
    int v, e;
    logic [7:0] fm;
    if (m_run[i] == 0) return 21'd0;
    if (m_run[i] == 2) begin
      e = popc(m_bad[i]);
      return {3'b000, 3'd7, 1'b0, 1'b1, (e == 0), 4'(e), m_bad[i]};
    end
    v  = m_t[i] / sp;
    e  = 0;
    fm = 8'd0;
    for (int j = 0; j < 8; j++) begin
      if ((j + 1) * sp <= m_t[i] && m_bad[i][j]) begin
        e++;
        fm[j] = 1'b1;
      end
    end
    return {v[0], v[1], v[2], 3'(v), 1'b1, 1'b0, 1'b0, 4'(e), fm};
  endfunction

  function automatic logic [20:0] dut_out(int i);
    return {a_o[i], b_o[i], c_o[i], vec_o[i], busy_o[i], done_o[i], pass_o[i], err_o[i], fail_o[i]};
  endfunction

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) chk("cycle_outputs", i, 32'(dut_out(i)), 32'(model_out(i)));
    end
  end

  // Random glitches on result_in everywhere except the cycle it is scored.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (m_run[i] == 1 && (m_t[i] % (SC[i] + 1)) == SC[i]) glitch[i] = 1'b0;
      else glitch[i] = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Start a run, optionally pulse start again at two cycle offsets, wait for done.
  task automatic run(input int x1, input int x2, output int n0, output int n1);
    n0 = 0;
    n1 = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clear", 0, 32'({busy_o[0], done_o[0], pass_o[0], err_o[0], fail_o[0]}), 32'h4000);
    while (!done_o[0] && n0 < 200) begin
      if (n0 == x1 || n0 == x2) start = 1'b1;
      step();
      start = 1'b0;
      n0++;
      if (done_o[1] && n1 < 0) n1 = n0;
    end
  endtask

  int c0, c1;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; rmask = 8'd0;
    glitch[0] = 1'b0; glitch[1] = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_state", 0, 32'(dut_out(0)), 32'd0);

    // Correct unit
    mode = 3'd0;
    run(-1, -1, c0, c1);
    chk("latency_s2", 0, c0, 24);
    chk("latency_s1", 1, c1, 16);
    chk("good_verdict", 0, 32'({pass_o[0], err_o[0], fail_o[0]}), 32'h1000);
    chk("good_verdict", 1, 32'({pass_o[1], err_o[1], fail_o[1]}), 32'h1000);

    // Vector 3 inverted
    mode = 3'd1;
    run(-1, -1, c0, c1);
    chk("inv3_verdict", 0, 32'({pass_o[0], err_o[0], fail_o[0]}), 32'h0108);

    // Stuck at 0, then hold in DONE
    mode = 3'd2;
    run(-1, -1, c0, c1);
    chk("stuck0_verdict", 0, 32'({pass_o[0], err_o[0], fail_o[0]}), 32'h05F8);
    repeat (10) step();
    chk("done_hold", 0, 32'({done_o[0], err_o[0], fail_o[0]}), 32'h15F8);

    // Stuck at 1, restarted from DONE
    mode = 3'd3;
    run(-1, -1, c0, c1);
    chk("stuck1_verdict", 0, 32'({pass_o[0], err_o[0], fail_o[0]}), 32'h0307);
    chk("restart_latency", 0, c0, 24);

    // Extra starts during the run are ignored
    mode = 3'd0;
    run(5, 12, c0, c1);
    chk("extra_start_latency", 0, c0, 24);
    chk("extra_start_verdict", 0, 32'({pass_o[0], err_o[0], fail_o[0]}), 32'h1000);

    // Reset while vector 4 is applied
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("pre_reset_vec", 0, 32'(vec_o[0]), 32'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_reset_zero", 0, 32'(dut_out(0)), 32'd0);
    chk("mid_reset_zero", 1, 32'(dut_out(1)), 32'd0);
    mode = 3'd1;
    run(-1, -1, c0, c1);
    chk("post_reset_latency", 0, c0, 24);
    chk("post_reset_verdict", 0, 32'({pass_o[0], err_o[0], fail_o[0]}), 32'h0108);

    // Random fault masks, idle gaps and stray starts
    for (int r = 0; r < 8; r++) begin
      mode  = 3'd4;
      rmask = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
      run(int'($urandom_range(1, 14)), int'($urandom_range(1, 14)), c0, c1);
      chk("rand_latency", 0, c0, 24);
      chk("rand_fail_map", 0, 32'(fail_o[0]), 32'(rmask));
      chk("rand_fail_map", 1, 32'(fail_o[1]), 32'(rmask));
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
